// File: rtl/ppfifo_pattern_source_if.sv
// ppfifo_pattern_source_if: ping-pong FIFO write-side bus.
// The master modport is the pattern source, the slave modport is the FIFO.
interface ppfifo_pattern_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            write_ready;
    logic [1:0]            write_activate;
    logic [23:0]           write_size;
    logic                  write_strobe;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        input  write_ready,
        input  write_size,
        output write_activate,
        output write_strobe,
        output write_data
    );

    modport slave (
        output write_ready,
        output write_size,
        input  write_activate,
        input  write_strobe,
        input  write_data
    );
endinterface

// File: rtl/ppfifo_pattern_source.sv
// ppfifo_pattern_source: fills ping-pong FIFO halves with an incrementing
// data pattern, starting at a programmable value, for a programmable word
// count, with optional idle gaps after every word.
// Optional feature macro: PATTERN_SOURCE_WRAP_EN -- when defined the pattern
// counts modulo 2^WRAP_WIDTH (start value masked on latch); otherwise the
// pattern is a plain DATA_WIDTH-bit increment and WRAP_WIDTH has no effect.
module ppfifo_pattern_source #(
    parameter int DATA_WIDTH = 32,
    parameter int WRAP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   start_value_i,
    input  logic [23:0]             total_count_i,
    input  logic [3:0]              gap_cycles_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [23:0]             words_sent_o,
    ppfifo_pattern_source_if.master wr
);

`ifdef PATTERN_SOURCE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] LOW_MASK =
        (WRAP_WIDTH >= DATA_WIDTH) ? {DATA_WIDTH{1'b1}}
                                   : ((DATA_WIDTH'(1) << WRAP_WIDTH) - DATA_WIDTH'(1));
    localparam logic [DATA_WIDTH-1:0] PAT_MASK = WRAP_EN ? LOW_MASK : {DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRAB    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Restricts a value to the active pattern range.
    function automatic logic [DATA_WIDTH-1:0] pattern_mask(input logic [DATA_WIDTH-1:0] value);
        return value & PAT_MASK;
    endfunction

    // Next pattern word; rolls over at the top of the active range.
    function automatic logic [DATA_WIDTH-1:0] pattern_next(input logic [DATA_WIDTH-1:0] value);
        return pattern_mask(value + DATA_WIDTH'(1));
    endfunction

    state_t                state_q,      state_d;
    logic [1:0]            activate_q,   activate_d;
    logic                  strobe_q,     strobe_d;
    logic [DATA_WIDTH-1:0] data_q,       data_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic [23:0]           words_sent_q, words_sent_d;
    logic [DATA_WIDTH-1:0] pattern_q,    pattern_d;
    logic [23:0]           remaining_q,  remaining_d;
    logic [23:0]           chunk_q,      chunk_d;
    logic [3:0]            gap_q,        gap_d;
    logic [3:0]            gap_load_q,   gap_load_d;

    logic                  half_full_s;
    logic                  last_word_s;

    // The half is exhausted, or the word about to be strobed is the last one
    // of this half / of the transfer (lets the release follow the last strobe
    // on the very next cycle).
    assign half_full_s = (chunk_q >= wr.write_size) || (remaining_q == 24'd0);
    assign last_word_s = ((chunk_q + 24'd1) >= wr.write_size) || (remaining_q == 24'd1);

    // Next-state and output decode for the fill sequencer.
    always_comb begin
        state_d      = state_q;
        activate_d   = activate_q;
        strobe_d     = 1'b0;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        words_sent_d = words_sent_q;
        pattern_d    = pattern_q;
        remaining_d  = remaining_q;
        chunk_d      = chunk_q;
        gap_load_d   = gap_load_q;
        if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pattern_d    = pattern_mask(start_value_i);
                    remaining_d  = total_count_i;
                    gap_load_d   = gap_cycles_i;
                    gap_d        = 4'd0;
                    words_sent_d = 24'd0;
                    busy_d       = 1'b1;
                    if (total_count_i == 24'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GRAB;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRAB: begin
                if ((activate_q == 2'b00) && (wr.write_ready != 2'b00)) begin
                    // Half 0 has priority when both are free.
                    if (wr.write_ready[0]) begin
                        activate_d = 2'b01;
                    end else begin
                        activate_d = 2'b10;
                    end
                    chunk_d = 24'd0;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_GRAB;
                end
            end

            ST_WRITE: begin
                if (half_full_s) begin
                    // Only reachable for a zero-sized half: release it empty.
                    state_d = ST_RELEASE;
                end else if (gap_q == 4'd0) begin
                    strobe_d     = 1'b1;
                    data_d       = pattern_q;
                    pattern_d    = pattern_next(pattern_q);
                    chunk_d      = chunk_q + 24'd1;
                    words_sent_d = words_sent_q + 24'd1;
                    remaining_d  = remaining_q - 24'd1;
                    gap_d        = gap_load_q;
                    if (last_word_s) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_RELEASE: begin
                activate_d = 2'b00;
                if (remaining_q != 24'd0) begin
                    state_d = ST_GRAB;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                activate_d = 2'b00;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any owned half at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            activate_q   <= 2'b00;
            strobe_q     <= 1'b0;
            data_q       <= {DATA_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_sent_q <= 24'd0;
            pattern_q    <= {DATA_WIDTH{1'b0}};
            remaining_q  <= 24'd0;
            chunk_q      <= 24'd0;
            gap_q        <= 4'd0;
            gap_load_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            activate_q   <= activate_d;
            strobe_q     <= strobe_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            words_sent_q <= words_sent_d;
            pattern_q    <= pattern_d;
            remaining_q  <= remaining_d;
            chunk_q      <= chunk_d;
            gap_q        <= gap_d;
            gap_load_q   <= gap_load_d;
        end
    end

    assign wr.write_activate = activate_q;
    assign wr.write_strobe   = strobe_q;
    assign wr.write_data     = data_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign words_sent_o      = words_sent_q;

endmodule

// File: doc/ppfifo_pattern_source.md
# ppfifo_pattern_source

Directed-test stimulus stage that sits directly upstream of the memory test device's write side, in the DMA simulation bench. Fills ping-pong FIFO halves with an incrementing 32-bit data pattern: a programmable start value and total word count, with optional idle gaps between words. Ports map one-to-one onto the ping-pong FIFO write interface. The downstream sequence checker sees a gap-free +1 sequence across FIFO halves.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write_data and start_value
- WRAP_WIDTH, 8, pattern modulus exponent; used only when the wrap feature is compiled in

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- start_value  in  DATA_WIDTH  first data word; latched on accepted start
- total_count  in  24  words to send; latched on accepted start
- gap_cycles  in  4  idle cycles inserted after every strobe; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transfer completes
- words_sent  out  24  running count of strobed words; cleared on accepted start
- write_ready  in  2  FIFO halves available
- write_activate  out  2  FIFO half owned; at most one bit set
- write_size  in  24  capacity of an activated half
- write_strobe  out  1  one word written this cycle
- write_data  out  DATA_WIDTH  valid when write_strobe is high

## Operation
- Reset values: write_activate=0, write_strobe=0, write_data=0, busy=0, done=0, words_sent=0. FSM=IDLE.
- IDLE:
  - start=1 latches start_value, total_count and gap_cycles, clears words_sent, sets busy.
  - total_count=0 goes straight to DONE with no FIFO activity; otherwise go to GRAB.
- GRAB:
  - Wait for write_activate==0 and write_ready!=0.
  - Set write_activate[0] if write_ready[0] is high, else write_activate[1]. Bit 0 wins when both halves are ready.
  - Clear the chunk counter and go to WRITE.
- WRITE:
  - Strobe one word when chunk counter < write_size, remaining > 0 and the gap counter is 0.
  - Each strobe: write_data = current pattern value. Pattern value, chunk counter and words_sent increment. Remaining decrements. Gap counter loads gap_cycles.
  - Gap counter decrements every non-strobe cycle while it is nonzero.
  - When chunk counter == write_size or remaining == 0, go to RELEASE.
- RELEASE:
  - Drive write_activate to 0 for one cycle.
  - Go to GRAB if remaining > 0, else DONE.
  - A half is never released with zero words written, except when write_size==0; then it is released empty and regrabbed.
- DONE: one-cycle done pulse, busy cleared, return to IDLE. start is ignored while busy.
- Pattern arithmetic: pattern + 1, truncated to DATA_WIDTH; 0xFFFFFFFF rolls over to 0.
- Remaining and word counters are 24-bit. total_count up to 2^24-1 is supported.
- Asynchronous rst mid-transfer immediately forces all reset values. No partial state survives, and the FIFO half is simply abandoned.

## Timing
- start at cycle N: busy=1 and FSM in GRAB at N+1. write_activate can be set at N+2 if a half is ready at N+1.
- First write_strobe occurs the cycle after write_activate rises. write_strobe and write_data are registered outputs.
- With gap_cycles=0: one word per cycle, sustained through the whole half.
- With gap_cycles=G: consecutive strobes are exactly G+1 cycles apart.
- The last strobe of a half is followed by write_activate=0 on the next cycle. No strobe ever occurs while write_activate==0.
- After release, the next activate needs at least one cycle (GRAB sample).
- done asserts the cycle after the final RELEASE. For total_count=0, done asserts at N+2.

## Configuration
- PATTERN_SOURCE_WRAP_EN defined: pattern value is computed modulo 2^WRAP_WIDTH.
  - After 2^WRAP_WIDTH-1 the next word is 0.
  - start_value is masked to WRAP_WIDTH bits on latch, and upper data bits are always 0.
  - This matches a memory sized to 2^WRAP_WIDTH words.
- Not defined: full DATA_WIDTH increment, WRAP_WIDTH ignored.

## Test plan
- Single half: start_value=0, total_count=8, write_size=8, gap=0, both halves ready.
  - Expect write_activate=01 and 8 back-to-back strobes with data 0..7.
  - Expect release, then done one cycle later, words_sent=8.
- Split across halves: total_count=20, write_size=8.
  - Expect halves 01,10,01 carrying 8,8,4 words, data 0..19 contiguous, exactly one done.
- Gap insertion: total_count=4, gap_cycles=3.
  - Expect strobes 4 cycles apart, data start_value..start_value+3.
- Wrap, macro defined with WRAP_WIDTH=8: start_value=0xFE, total_count=4.
  - Expect data FE, FF, 00, 01.
  - Macro undefined, start_value=0xFFFFFFFF, total_count=2: expect data FFFFFFFF, 00000000.
- Zero count and reset: total_count=0.
  - Expect done two cycles after start, no write_activate.
  - Mid-transfer, assert rst between clock edges: outputs go to 0 immediately, and a new start afterwards restarts from start_value.
